spi_rx_deserializer: RTL and testbench

//  Downstream stage of the SPI master. Consumes the per-bit strobe/data stream the master emits on

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_rx_fifo.sv | 64 ++++++
 rtl/spi_rx_deserializer.sv | 164 ++++++++++++++++
 tb/tb_spi_rx_deserializer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and default sizes for the SPI receive path.
// Optional build macro used by the deserializer: SPI_RX_PARTIAL_FLUSH_EN.
package spi_pkg;

    // Receive FSM: waiting for a frame, or collecting bits inside one.
    typedef enum logic [0:0] {
        StIdle,
        StCollect
    } rx_state_t;

    localparam int unsigned SPI_RX_DATA_W     = 8;
    localparam int unsigned SPI_RX_FIFO_DEPTH = 4;

endpackage

// File: rtl/spi_rx_fifo.sv
// Synchronous first-word-fall-through FIFO. The head word is visible on pop_data_o
// whenever empty_o is low. A push while full is accepted only if a pop happens in the
// same cycle; otherwise it is dropped and the caller decides what to flag.
module spi_rx_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   level_o
);

    localparam int unsigned AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             push_ok;
    logic             pop_ok;

    // Status flags and qualified push/pop.
    always_comb begin
        full_o  = (level_q == (AW+1)'(Depth));
        empty_o = (level_q == '0);
        push_ok = push_i && (!full_o || pop_i);
        pop_ok  = pop_i && !empty_o;
        // Drive zero when empty so the output is clean after reset and drain.
        pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
        level_o    = level_q;
    end

    // Storage, pointers and occupancy; pointers wrap naturally (Depth is a power of two).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/spi_rx_deserializer.sv
// Assembles DATA_W-bit words from the SPI master's per-bit strobe/data stream and buffers
// them in a FWFT FIFO with a valid/ready output. Flags dropped words (overflow) and frames
// that end mid-word.
// Build macro SPI_RX_PARTIAL_FLUSH_EN: when defined, a partial word at frame end is
// zero-padded and pushed instead of raising frame_err_o.
module spi_rx_deserializer
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W     = SPI_RX_DATA_W,
    parameter int unsigned FIFO_DEPTH = SPI_RX_FIFO_DEPTH,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            frame_i,
    input  logic                            bit_we_i,
    input  logic                            bit_wd_i,
    input  logic                            clr_i,
    output logic [DATA_W-1:0]               m_data_o,
    output logic                            m_valid_o,
    input  logic                            m_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]     level_o,
    output logic                            overflow_o,
    output logic                            frame_err_o
);

    localparam int unsigned CW = $clog2(DATA_W);

    rx_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] sh_next;
    logic              overflow_q, overflow_d;
    logic              frame_err_q, frame_err_d;

    logic              accept;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic              frame_err_set;
    logic              overflow_set;
    logic              fifo_full;
    logic              fifo_empty;

    // Shift register value after accepting the current bit.
    always_comb begin
        accept = bit_we_i && frame_i;
        if (MSB_FIRST) begin
            sh_next = {sh_q[DATA_W-2:0], bit_wd_i};
        end else begin
            sh_next = {bit_wd_i, sh_q[DATA_W-1:1]};
        end
    end

`ifdef SPI_RX_PARTIAL_FLUSH_EN
    logic [DATA_W-1:0] partial_word;
    int unsigned       pad_amt;

    // Shift the received bits to their final alignment; vacated positions fill with zeros
    // and any stale bits from an earlier word are shifted out.
    always_comb begin
        pad_amt = DATA_W - 32'(cnt_q);
        if (MSB_FIRST) begin
            partial_word = sh_q << pad_amt;
        end else begin
            partial_word = sh_q >> pad_amt;
        end
    end
`endif

    // FSM next state, bit collection and word push generation.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sh_d          = sh_q;
        push          = 1'b0;
        push_data     = sh_next;
        frame_err_set = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (frame_i) begin
                    state_d = StCollect;
                end
            end
            StCollect: begin
                if (!frame_i) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    sh_d    = '0;
                    if (cnt_q != '0) begin
`ifdef SPI_RX_PARTIAL_FLUSH_EN
                        push      = 1'b1;
                        push_data = partial_word;
`else
                        frame_err_set = 1'b1;
`endif
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // accept implies frame_i=1, so it never overlaps the frame-end branch above.
        if (accept) begin
            sh_d = sh_next;
            if (cnt_q == CW'(DATA_W - 1)) begin
                cnt_d     = '0;
                push      = 1'b1;
                push_data = sh_next;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Sticky flags: a set in the same cycle wins over clr_i.
    always_comb begin
        pop          = m_valid_o && m_ready_i;
        overflow_set = push && fifo_full && !pop;
        overflow_d   = overflow_set  ? 1'b1 : (clr_i ? 1'b0 : overflow_q);
        frame_err_d  = frame_err_set ? 1'b1 : (clr_i ? 1'b0 : frame_err_q);
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            sh_q        <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    spi_rx_fifo #(
        .Width (DATA_W),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .pop_data_o  (m_data_o),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (level_o)
    );

    // Output mapping.
    always_comb begin
        m_valid_o   = !fifo_empty;
        overflow_o  = overflow_q;
        frame_err_o = frame_err_q;
    end

endmodule

// File: tb/tb_spi_rx_deserializer.sv
// Self-checking bench for spi_rx_deserializer: directed scenarios plus randomized frames
// checked against a word-level reference model. Honours SPI_RX_PARTIAL_FLUSH_EN.
module tb_spi_rx_deserializer;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam bit MSB   = 1'b1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          frame_i;
    logic          bit_we_i;
    logic          bit_wd_i;
    logic          clr_i;
    logic [DW-1:0] m_data_o;
    logic          m_valid_o;
    logic          m_ready_i;
    logic [2:0]    level_o;
    logic          overflow_o;
    logic          frame_err_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] got_q[$];
    logic [DW-1:0] exp_q[$];

    spi_rx_deserializer #(
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH),
        .MSB_FIRST  (MSB)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .frame_i     (frame_i),
        .bit_we_i    (bit_we_i),
        .bit_wd_i    (bit_wd_i),
        .clr_i       (clr_i),
        .m_data_o    (m_data_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .level_o     (level_o),
        .overflow_o  (overflow_o),
        .frame_err_o (frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Record every handshake; inputs change 1 time unit after posedge, so the negedge sees
    // exactly what the next posedge will see.
    always @(negedge clk_i) begin
        if (!rst_i && m_valid_o && m_ready_i) got_q.push_back(m_data_o);
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_bit(input logic b);
        frame_i  = 1'b1;
        bit_we_i = 1'b1;
        bit_wd_i = b;
        cyc();
        bit_we_i = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        for (int i = 0; i < DW; i++) send_bit(MSB ? w[DW-1-i] : w[i]);
    endtask

    task automatic end_frame();
        frame_i = 1'b0;
        cyc();
    endtask

    task automatic pulse_clr();
        clr_i = 1'b1;
        cyc();
        clr_i = 1'b0;
    endtask

    // Compare captured words against the expected list.
    task automatic check_words(input string name);
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_err++;
            $display("FAIL %s count: got %0d words, expected %0d", name, got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL %s word %0d: got %h expected %h", name, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({m_data_o, m_valid_o, level_o, overflow_o, frame_err_o} !== '0) begin
            n_err++;
            $display("FAIL reset outputs: data=%h valid=%b level=%0d ovf=%b ferr=%b expected all 0",
                     m_data_o, m_valid_o, level_o, overflow_o, frame_err_o);
        end
    endtask

    task automatic test_single_word();
        logic [DW-1:0] w;
        w = 8'hA5;
        got_q.delete();
        m_ready_i = 1'b1;
        for (int i = 0; i < DW - 1; i++) send_bit(w[DW-1-i]);
        n_cmp++;
        if (m_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL single early_valid: got %b expected 0", m_valid_o);
        end
        send_bit(w[0]);
        n_cmp++;
        if (m_valid_o !== 1'b1 || m_data_o !== 8'hA5) begin
            n_err++;
            $display("FAIL single word: valid=%b data=%h expected valid=1 data=a5", m_valid_o, m_data_o);
        end
        cyc();
        n_cmp++;
        if (m_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL single valid_width: valid=%b one cycle later, expected 0", m_valid_o);
        end
        end_frame();
        n_cmp++;
        if (frame_err_o !== 1'b0 || got_q.size() !== 1) begin
            n_err++;
            $display("FAIL single tail: ferr=%b pops=%0d expected ferr=0 pops=1", frame_err_o, got_q.size());
        end
    endtask

    task automatic test_two_words();
        got_q.delete();
        m_ready_i = 1'b0;
        send_word(8'h3C);
        send_word(8'hC3);
        end_frame();
        n_cmp++;
        if (level_o !== 3'd2 || m_data_o !== 8'h3C) begin
            n_err++;
            $display("FAIL two_words hold: level=%0d data=%h expected level=2 data=3c", level_o, m_data_o);
        end
        m_ready_i = 1'b1;
        repeat (3) cyc();
        exp_q = '{8'h3C, 8'hC3};
        check_words("two_words");
        n_cmp++;
        if (level_o !== 3'd0) begin
            n_err++;
            $display("FAIL two_words level: got %0d expected 0", level_o);
        end
    endtask

    task automatic test_overflow();
        got_q.delete();
        m_ready_i = 1'b0;
        for (int i = 1; i <= 5; i++) send_word(8'(i));
        end_frame();
        n_cmp++;
        if (overflow_o !== 1'b1 || level_o !== 3'd4) begin
            n_err++;
            $display("FAIL overflow set: ovf=%b level=%0d expected ovf=1 level=4", overflow_o, level_o);
        end
        m_ready_i = 1'b1;
        repeat (6) cyc();
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        check_words("overflow_drain");
        n_cmp++;
        if (overflow_o !== 1'b1) begin
            n_err++;
            $display("FAIL overflow sticky: got %b expected 1", overflow_o);
        end
        m_ready_i = 1'b0;
        pulse_clr();
        n_cmp++;
        if (overflow_o !== 1'b0) begin
            n_err++;
            $display("FAIL overflow clr: got %b expected 0", overflow_o);
        end
    endtask

    task automatic test_full_push_pop();
        logic [DW-1:0] w;
        got_q.delete();
        m_ready_i = 1'b0;
        send_word(8'h11);
        send_word(8'h22);
        send_word(8'h33);
        send_word(8'h44);
        w = 8'h55;
        for (int i = 0; i < DW - 1; i++) send_bit(w[DW-1-i]);
        m_ready_i = 1'b1;
        send_bit(w[0]);
        m_ready_i = 1'b0;
        end_frame();
        n_cmp++;
        if (level_o !== 3'd4 || overflow_o !== 1'b0 || m_data_o !== 8'h22) begin
            n_err++;
            $display("FAIL full_push_pop: level=%0d ovf=%b data=%h expected level=4 ovf=0 data=22",
                     level_o, overflow_o, m_data_o);
        end
        m_ready_i = 1'b1;
        repeat (6) cyc();
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        check_words("full_push_pop");
    endtask

    task automatic test_partial_frame();
        logic exp_ferr;
        pulse_clr();
        got_q.delete();
        m_ready_i = 1'b1;
        send_word(8'h81);
        repeat (4) send_bit(1'b1);
        end_frame();
        repeat (3) cyc();
`ifdef SPI_RX_PARTIAL_FLUSH_EN
        exp_q    = '{8'h81, 8'hF0};
        exp_ferr = 1'b0;
`else
        exp_q    = '{8'h81};
        exp_ferr = 1'b1;
`endif
        check_words("partial");
        n_cmp++;
        if (frame_err_o !== exp_ferr) begin
            n_err++;
            $display("FAIL partial frame_err: got %b expected %b", frame_err_o, exp_ferr);
        end
        pulse_clr();
        n_cmp++;
        if (frame_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL partial clr: got %b expected 0", frame_err_o);
        end
    endtask

    task automatic test_async_reset();
        got_q.delete();
        m_ready_i = 1'b0;
        send_word(8'h77);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        n_cmp++;
        if (m_valid_o !== 1'b1 || level_o !== 3'd1) begin
            n_err++;
            $display("FAIL areset pre: valid=%b level=%0d expected valid=1 level=1", m_valid_o, level_o);
        end
        #2;
        rst_i = 1'b1;
        #1;
        n_cmp++;
        if ({m_data_o, m_valid_o, level_o, overflow_o, frame_err_o} !== '0) begin
            n_err++;
            $display("FAIL areset immediate: data=%h valid=%b level=%0d expected all 0",
                     m_data_o, m_valid_o, level_o);
        end
        frame_i = 1'b0;
        cyc();
        rst_i = 1'b0;
        m_ready_i = 1'b1;
        for (int i = 0; i < 2 * DW; i++) begin
            bit_we_i = 1'b1;
            bit_wd_i = 1'($urandom_range(0, 1));
            cyc();
        end
        bit_we_i = 1'b0;
        n_cmp++;
        if (level_o !== 3'd0 || got_q.size() !== 0) begin
            n_err++;
            $display("FAIL areset ignore: level=%0d pops=%0d expected 0 and 0", level_o, got_q.size());
        end
        send_word(8'h5A);
        end_frame();
        repeat (2) cyc();
        exp_q = '{8'h5A};
        check_words("areset_new_frame");
        n_cmp++;
        if (frame_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL areset frame_err: got %b expected 0", frame_err_o);
        end
    endtask

    task automatic test_random();
        logic bits[$];
        logic exp_ferr;
        int   n;
        int   k;
        logic [DW-1:0] w;
        pulse_clr();
        got_q.delete();
        exp_q.delete();
        exp_ferr = 1'b0;
        for (int f = 0; f < 30; f++) begin
            bits.delete();
            n = $urandom_range(1, 3 * DW);
            for (int i = 0; i < n; i++) bits.push_back(1'($urandom_range(0, 1)));
            // Reference: chop the bit list into words, last one possibly partial.
            for (int base = 0; base < n; base += DW) begin
                k = (n - base < DW) ? n - base : DW;
                w = '0;
                for (int j = 0; j < k; j++) begin
                    if (MSB) w[DW-1-j] = bits[base+j];
                    else     w[j]      = bits[base+j];
                end
                if (k == DW) begin
                    exp_q.push_back(w);
                end else begin
`ifdef SPI_RX_PARTIAL_FLUSH_EN
                    exp_q.push_back(w);
`else
                    exp_ferr = 1'b1;
`endif
                end
            end
            // Drive the frame with random gaps and random consumer back-pressure.
            frame_i = 1'b1;
            for (int i = 0; i < n; i++) begin
                m_ready_i = ($urandom_range(0, 3) != 0);
                if (i != 0) begin
                    repeat ($urandom_range(0, 2)) cyc();
                end
                send_bit(bits[i]);
            end
            frame_i = 1'b0;
            repeat ($urandom_range(1, 3)) begin
                bit_we_i  = 1'($urandom_range(0, 1));
                bit_wd_i  = 1'($urandom_range(0, 1));
                m_ready_i = ($urandom_range(0, 3) != 0);
                cyc();
            end
            bit_we_i = 1'b0;
        end
        m_ready_i = 1'b1;
        repeat (DEPTH + 4) cyc();
        check_words("random");
        n_cmp++;
        if (frame_err_o !== exp_ferr || overflow_o !== 1'b0 || level_o !== 3'd0) begin
            n_err++;
            $display("FAIL random flags: ferr=%b ovf=%b level=%0d expected ferr=%b ovf=0 level=0",
                     frame_err_o, overflow_o, level_o, exp_ferr);
        end
    endtask

    initial begin
        rst_i     = 1'b0;
        frame_i   = 1'b0;
        bit_we_i  = 1'b0;
        bit_wd_i  = 1'b0;
        clr_i     = 1'b0;
        m_ready_i = 1'b0;
        #1;
        rst_i = 1'b1;
        #2;
        test_reset();
        cyc();
        cyc();
        rst_i = 1'b0;
        cyc();
        test_single_word();
        test_two_words();
        test_overflow();
        test_full_push_pop();
        test_partial_frame();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
